// File: rtl/scan_loader_pkg.sv
// scan_loader shared types
// State encoding and default config chain length
package scan_loader_pkg;

    // Config chain length in bytes; the chain derives its bit length from this
    localparam int CFG_BYTES_DEF = 144;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/scan_loader_if.sv
// scan_loader byte input handshake
// Source drives data/valid, loader returns ready
interface scan_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/scan_loader_byte_serdes.sv
// byte_serdes: 8-bit tx/rx shift pair for the scan chain
// tx shifts MSB-first, rx collects returned bits
module byte_serdes (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    input  logic       sin,
    output logic       sout,
    output logic [7:0] pout,
    output logic       last
);
    logic [7:0] tx;
    logic [6:0] rx;
    logic [2:0] cnt;

    // load restarts the byte; each shift moves one bit out and one in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx  <= '0;
            rx  <= '0;
            cnt <= '0;
        end else if (load) begin
            tx  <= din;
            cnt <= '0;
        end else if (shift) begin
            tx  <= {tx[6:0], 1'b0};
            rx  <= {rx[5:0], sin};
            cnt <= cnt + 3'd1;
        end
    end

    assign sout = tx[7];
    // byte as it stands once the current serial bit is taken in
    assign pout = {rx, sin};
    assign last = (cnt == 3'd7);
endmodule

// File: rtl/scan_loader.sv
// scan_loader: byte-stream loader for the enforcer config chain
// Serialises bytes MSB-first, captures readback, gates core reset
module scan_loader
    import scan_loader_pkg::*;
#(
    parameter int CFG_BYTES  = CFG_BYTES_DEF,
    parameter int CLR_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    scan_loader_if.slave cfg,
    output logic         scan_in,
    output logic         scan_en,
    output logic         scan_reset,
    input  logic         scan_out,
    output logic [7:0]   rd_data,
    output logic         rd_valid,
    output logic         core_reset,
    output logic         busy,
    output logic         done
);
    localparam int BW = $clog2(CFG_BYTES + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(CFG_BYTES - 1);
    localparam logic [CW-1:0] LAST_CLR  = CW'(CLR_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [BW-1:0] bytes;
    logic [CW-1:0] clr_cnt;
    logic          ready_q;
    logic          load;
    logic          shift;
    logic          last;
    logic          byte_end;
    logic          tx_bit;
    logic [7:0]    rx_word;

    assign load     = (state == ST_WAIT) && cfg.in_valid;
    assign shift    = (state == ST_SHIFT);
    assign byte_end = shift && last && !abort;

    assign cfg.in_ready = ready_q;
    // tx keeps stale bits after an abort, so only drive data while shifting
    assign scan_in = scan_en && tx_bit;

    byte_serdes u_serdes (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (cfg.in_data),
        .sin   (scan_out),
        .sout  (tx_bit),
        .pout  (rx_word),
        .last  (last)
    );

    // next-state: abort overrides every transition
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == LAST_CLR) state_nx = ST_WAIT;
            ST_WAIT:  if (cfg.in_valid) state_nx = ST_SHIFT;
            ST_SHIFT: if (last) state_nx = (bytes == LAST_BYTE) ? ST_DONE : ST_WAIT;
            ST_DONE:  if (start) state_nx = ST_CLEAR;
            default:  state_nx = ST_IDLE;
        endcase
        if (abort) state_nx = ST_IDLE;
    end

    // clear-phase timer and completed-byte counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
            bytes   <= '0;
        end else begin
            clr_cnt <= (state == ST_CLEAR) ? clr_cnt + CW'(1) : '0;
            if (state == ST_CLEAR) bytes <= '0;
            else if (byte_end)     bytes <= bytes + BW'(1);
        end
    end

    // state register plus registered outputs decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            scan_en    <= 1'b0;
            scan_reset <= 1'b0;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_reset <= 1'b1;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            state      <= state_nx;
            scan_en    <= (state_nx == ST_SHIFT);
            scan_reset <= (state_nx == ST_CLEAR);
            ready_q    <= (state_nx == ST_WAIT);
            busy       <= state_nx inside {ST_CLEAR, ST_WAIT, ST_SHIFT};
            done       <= (state_nx == ST_DONE);
            core_reset <= (state_nx != ST_DONE);
            rd_valid   <= byte_end;
            if (byte_end) rd_data <= rx_word;
        end
    end
endmodule

// File: tb/tb_scan_loader.sv
// tb_scan_loader: single-byte vector table plus full 144-byte loads
// Chain is modelled as a plain bit array; readback compared to its snapshot
module tb_scan_loader;
    import scan_loader_pkg::*;

    localparam int NB    = CFG_BYTES_DEF;
    localparam int NBITS = NB * 8;
    localparam int CLR   = 2;

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] pre;
        logic [7:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    scan_loader_if ifa ();
    scan_loader_if ifb ();

    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;
    logic sin_a, sen_a, srst_a, sout_a, rdv_a, crst_a, busy_a, done_a;
    logic sin_b, sen_b, srst_b, sout_b, rdv_b, crst_b, busy_b, done_b;
    logic [7:0] rdd_a, rdd_b;

    scan_loader #(.CFG_BYTES(1), .CLR_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .cfg(ifa), .scan_in(sin_a), .scan_en(sen_a), .scan_reset(srst_a),
        .scan_out(sout_a), .rd_data(rdd_a), .rd_valid(rdv_a),
        .core_reset(crst_a), .busy(busy_a), .done(done_a)
    );

    scan_loader #(.CFG_BYTES(NB), .CLR_CYCLES(CLR)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .cfg(ifb), .scan_in(sin_b), .scan_en(sen_b), .scan_reset(srst_b),
        .scan_out(sout_b), .rd_data(rdd_b), .rd_valid(rdv_b),
        .core_reset(crst_b), .busy(busy_b), .done(done_b)
    );

    // chain models: bits enter at the bottom, leave from the top
    logic [7:0] chain_a;
    logic pre_a = 1'b0;
    logic [7:0] pre_val_a = '0;
    always @(posedge clk)
        if (pre_a) chain_a <= pre_val_a;
        else if (sen_a) chain_a <= {chain_a[6:0], sin_a};
    assign sout_a = chain_a[7];

    logic [NBITS-1:0] chain_b;
    logic pre_b = 1'b0;
    logic [NBITS-1:0] pre_val_b = '0;
    always @(posedge clk)
        if (pre_b) chain_b <= pre_val_b;
        else if (sen_b) chain_b <= {chain_b[NBITS-2:0], sin_b};
    assign sout_b = chain_b[NBITS-1];

    // readback log and shift-cycle count for the big instance
    logic [7:0] rd_log [$];
    int en_cnt = 0;
    always @(negedge clk) begin
        if (rdv_b) rd_log.push_back(rdd_b);
        if (sen_b) en_cnt <= en_cnt + 1;
    end

    logic [7:0] cur   [NB];
    logic [7:0] expv  [NB];
    logic [7:0] pat_p [NB];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic begin_b(input bit junk, output int ts, output int base, output int en0);
        base = rd_log.size();
        en0 = en_cnt;
        ts = cyc;
        start_b = 1'b1;
        tick();
        start_b = junk;
        chk("b_clr1", int'(srst_b), 1);
        chk("b_crst_clr", int'(crst_b), 1);
        tick();
        start_b = 1'b0;
        chk("b_clr2", int'(srst_b), 1);
        tick();
        chk("b_clr_end", int'(srst_b), 0);
        chk("b_ready", int'(ifb.in_ready), 1);
    endtask

    task automatic feed_b(input bit thr, input bit junk, input int n);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 20 * NB) begin
            ifb.in_valid = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
            ifb.in_data = cur[idx];
            start_b = junk && (guard % 50 == 25);
            if (ifb.in_valid && ifb.in_ready) idx++;
            tick();
            guard++;
        end
        ifb.in_valid = 1'b0;
        start_b = 1'b0;
        chk("b_feed_count", idx, n);
    endtask

    task automatic finish_b(input int base, input int en0, input int ts, input bit timed);
        int n = 0;
        int bad = 0;
        while (!done_b && n < 40) begin
            tick();
            n++;
        end
        chk("b_done", int'(done_b), 1);
        if (timed) chk("b_latency", cyc - ts, CLR + 9 * NB + 1);
        chk("b_core_reset_done", int'(crst_b), 0);
        chk("b_busy_done", int'(busy_b), 0);
        tick();
        chk("b_rd_count", rd_log.size() - base, NB);
        chk("b_en_count", en_cnt - en0, NBITS);
        for (int k = 0; k < NB; k++)
            if (base + k < rd_log.size() && rd_log[base + k] !== expv[k]) bad++;
        chk("b_readback", bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [4];
        int ts, base, en0;

        ifa.in_valid = 1'b0;
        ifa.in_data = '0;
        ifb.in_valid = 1'b0;
        ifb.in_data = '0;

        tv[0] = '{din: 8'hA5, pre: 8'h3C, rd: 8'h3C};
        tv[1] = '{din: 8'h00, pre: 8'hFF, rd: 8'hFF};
        tv[2] = '{din: 8'hFF, pre: 8'h00, rd: 8'h00};
        tv[3] = '{din: 8'h81, pre: 8'h5A, rd: 8'h5A};

        reset = 1'b0;
        tick();
        tick();
        chk("rst_scan_in", int'(sin_b), 0);
        chk("rst_scan_en", int'(sen_b), 0);
        chk("rst_scan_reset", int'(srst_b), 0);
        chk("rst_in_ready", int'(ifb.in_ready), 0);
        chk("rst_rd_data", int'(rdd_b), 0);
        chk("rst_rd_valid", int'(rdv_b), 0);
        chk("rst_busy", int'(busy_b), 0);
        chk("rst_done", int'(done_b), 0);
        chk("rst_core_reset", int'(crst_b), 1);
        chk("rst_core_reset_a", int'(crst_a), 1);
        reset = 1'b1;
        tick();

        // single-byte vectors on the one-byte chain
        for (int i = 0; i < 4; i++) begin
            pre_val_a = tv[i].pre;
            pre_a = 1'b1;
            tick();
            pre_a = 1'b0;
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            chk("a_clr1", int'(srst_a), 1);
            chk("a_crst_clr", int'(crst_a), 1);
            tick();
            chk("a_clr2", int'(srst_a), 1);
            tick();
            chk("a_clr_end", int'(srst_a), 0);
            chk("a_ready", int'(ifa.in_ready), 1);
            ifa.in_valid = 1'b1;
            ifa.in_data = tv[i].din;
            tick();
            ifa.in_valid = 1'b0;
            for (int b = 0; b < 8; b++) begin
                chk("a_scan_en", int'(sen_a), 1);
                chk("a_scan_in", int'(sin_a), int'(tv[i].din[7 - b]));
                chk("a_rd_quiet", int'(rdv_a), 0);
                tick();
            end
            chk("a_scan_en_off", int'(sen_a), 0);
            chk("a_rd_valid", int'(rdv_a), 1);
            chk("a_rd_data", int'(rdd_a), int'(tv[i].rd));
            chk("a_done", int'(done_a), 1);
            chk("a_busy", int'(busy_a), 0);
            chk("a_core_reset", int'(crst_a), 0);
            tick();
            chk("a_rd_pulse", int'(rdv_a), 0);
        end

        // load P over random chain contents, throttled input
        for (int i = 0; i < NBITS; i++) pre_val_b[i] = ($urandom_range(0, 1) != 0);
        pre_b = 1'b1;
        tick();
        pre_b = 1'b0;
        for (int k = 0; k < NB; k++) begin
            expv[k] = pre_val_b[NBITS - 1 - 8 * k -: 8];
            cur[k] = 8'($urandom_range(0, 255));
            pat_p[k] = cur[k];
        end
        begin_b(1'b0, ts, base, en0);
        feed_b(1'b1, 1'b0, NB);
        finish_b(base, en0, ts, 1'b0);

        // start+abort in DONE, then in IDLE: abort wins both times
        start_b = 1'b1;
        abort_b = 1'b1;
        tick();
        start_b = 1'b0;
        abort_b = 1'b0;
        chk("sa_done_cleared", int'(done_b), 0);
        chk("sa_core_reset", int'(crst_b), 1);
        chk("sa_busy", int'(busy_b), 0);
        start_b = 1'b1;
        abort_b = 1'b1;
        tick();
        start_b = 1'b0;
        abort_b = 1'b0;
        chk("sa_idle_srst", int'(srst_b), 0);
        chk("sa_idle_busy", int'(busy_b), 0);

        // load Q unthrottled with stray starts; readback must be P
        for (int k = 0; k < NB; k++) begin
            expv[k] = pat_p[k];
            cur[k] = 8'($urandom_range(0, 255));
        end
        begin_b(1'b1, ts, base, en0);
        feed_b(1'b0, 1'b1, NB);
        finish_b(base, en0, ts, 1'b1);

        // abort after 3 bits of byte 5
        begin_b(1'b0, ts, base, en0);
        feed_b(1'b0, 1'b0, 6);
        chk("ab_en1", int'(sen_b), 1);
        tick();
        chk("ab_en2", int'(sen_b), 1);
        tick();
        chk("ab_en3", int'(sen_b), 1);
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        chk("ab_en_drop", int'(sen_b), 0);
        chk("ab_busy", int'(busy_b), 0);
        chk("ab_core_reset", int'(crst_b), 1);
        chk("ab_srst", int'(srst_b), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("ab_rd_count", rd_log.size() - base, 5);
        chk("ab_en_count", en_cnt - en0, 43);

        // rerun from byte 0; readback is whatever the chain now holds
        for (int k = 0; k < NB; k++) begin
            expv[k] = chain_b[NBITS - 1 - 8 * k -: 8];
            cur[k] = 8'($urandom_range(0, 255));
        end
        begin_b(1'b0, ts, base, en0);
        feed_b(1'b1, 1'b0, NB);
        finish_b(base, en0, ts, 1'b0);

        // asynchronous reset in the middle of a shift
        cur[0] = 8'hC3;
        begin_b(1'b0, ts, base, en0);
        feed_b(1'b0, 1'b0, 1);
        tick();
        chk("rs_shifting", int'(sen_b), 1);
        #3;
        reset = 1'b0;
        #1;
        chk("rs_scan_in", int'(sin_b), 0);
        chk("rs_scan_en", int'(sen_b), 0);
        chk("rs_scan_reset", int'(srst_b), 0);
        chk("rs_in_ready", int'(ifb.in_ready), 0);
        chk("rs_rd_data", int'(rdd_b), 0);
        chk("rs_rd_valid", int'(rdv_b), 0);
        chk("rs_busy", int'(busy_b), 0);
        chk("rs_done", int'(done_b), 0);
        chk("rs_core_reset", int'(crst_b), 1);
        #2;
        reset = 1'b1;
        tick();
        chk("rs_idle_busy", int'(busy_b), 0);
        chk("rs_idle_srst", int'(srst_b), 0);
        chk("rs_idle_core_reset", int'(crst_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
